// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array output path.
package systolic_pkg;

  // BRAM address bus width.
  localparam int MEM_ADDR_W = 32;

  // Default array geometry; the row-word type is sized from it.
  localparam int DEF_COLS      = 4;
  localparam int DEF_WORD_SIZE = 16;

  // One complete output row as written to the BRAM.
  typedef logic [DEF_COLS*DEF_WORD_SIZE-1:0] row_word_t;

  // Write-back sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } wb_state_t;

endpackage

// File: rtl/wb_deskew_buffer.sv
// ROWS x COLS de-skew storage with per-column fill counters.
// row_complete and rd_data look ahead through the current capture so the
// top can register a row write on the same edge that stores its last element.
module wb_deskew_buffer #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int WORD_SIZE = 16,
  parameter int CNT_W     = $clog2(ROWS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      capture_en,
  input  logic [COLS-1:0]           eff_valid,
  input  logic [COLS*WORD_SIZE-1:0] eff_data,
  input  logic [CNT_W-1:0]          rd_row,
  output logic                      row_complete,
  output logic [COLS*WORD_SIZE-1:0] rd_data,
  output logic                      all_full,
  output logic                      overflow
);

  localparam int              IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ROWS);

  logic [CNT_W-1:0]     col_cnt [COLS];
  logic [WORD_SIZE-1:0] mem     [ROWS][COLS];
  logic [COLS-1:0]      take;
  logic [COLS-1:0]      ovf_hit;
  logic [CNT_W-1:0]     cnt_next;

  // Per-column accept/drop decisions, fill status and look-ahead row read.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    take         = '0;
    ovf_hit      = '0;
    cnt_next     = '0;
    all_full     = 1'b1;
    row_complete = (rd_row < FULL);
    rd_data      = '0;
    for (int c = 0; c < COLS; c++) begin
      take[c]    = capture_en && eff_valid[c] && (col_cnt[c] != FULL);
      ovf_hit[c] = capture_en && eff_valid[c] && (col_cnt[c] == FULL);
      if (col_cnt[c] != FULL) all_full = 1'b0;
      cnt_next = col_cnt[c] + CNT_W'(take[c]);
      if (cnt_next <= rd_row) row_complete = 1'b0;
      // Forward the element being captured now if it belongs to the read row.
      if (take[c] && (col_cnt[c] == rd_row))
        rd_data[c*WORD_SIZE +: WORD_SIZE] = eff_data[c*WORD_SIZE +: WORD_SIZE];
      else
        rd_data[c*WORD_SIZE +: WORD_SIZE] = mem[rd_row[IDX_W-1:0]][c];
    end
    overflow = |ovf_hit;
  end

  // Column fill counters: cleared on a new matrix, bumped per accepted element.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
    end else if (clear) begin
      for (int c = 0; c < COLS; c++) col_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++)
        if (take[c]) col_cnt[c] <= col_cnt[c] + 1'b1;
    end
  end

  // Element storage, addressed by the column's current fill count.
  // NOTE: the storage array is not reset; counters gate every read of stale entries.
  always_ff @(posedge clk) begin
    for (int c = 0; c < COLS; c++)
      if (take[c]) mem[col_cnt[c][IDX_W-1:0]][c] <= eff_data[c*WORD_SIZE +: WORD_SIZE];
  end

endmodule

// File: rtl/systolic_output_writeback.sv
// Systolic array output write-back: de-skews column results into rows and
// writes one row per BRAM word, pulsing done after the last row.
// Optional feature macro: WPROXY_MERGE_EN (merges weight-proxy valids/data).
module systolic_output_writeback
  import systolic_pkg::*;
#(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int WORD_SIZE      = 16,
  parameter int MEM_PORT_WIDTH = COLS * WORD_SIZE,
  parameter int BASE_ADDR      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [COLS-1:0]           col_valid,
  input  logic [COLS*WORD_SIZE-1:0] col_data,
`ifdef WPROXY_MERGE_EN
  input  logic [COLS-1:0]           proxy_valid,
  input  logic [COLS*WORD_SIZE-1:0] proxy_data,
`endif
  output logic [MEM_ADDR_W-1:0]     out_mem_addr,
  output logic                      out_mem_wr_en,
  output logic [MEM_PORT_WIDTH-1:0] out_mem_wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow_err
);

  localparam int CNT_W = $clog2(ROWS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROWS);

  wb_state_t                 state, state_nx;
  logic [CNT_W-1:0]          wr_row;
  logic [COLS-1:0]           eff_valid;
  logic [COLS*WORD_SIZE-1:0] eff_data;
  logic                      accept, in_flight, do_write;
  logic                      row_complete, all_full, overflow;
  logic [COLS*WORD_SIZE-1:0] rd_data;

  // Effective column valid/data, with the proxy taking priority when merged.
  always_comb begin
`ifdef WPROXY_MERGE_EN
    eff_valid = col_valid | proxy_valid;
    eff_data  = col_data;
    for (int c = 0; c < COLS; c++)
      if (proxy_valid[c]) eff_data[c*WORD_SIZE +: WORD_SIZE] = proxy_data[c*WORD_SIZE +: WORD_SIZE];
`else
    eff_valid = col_valid;
    eff_data  = col_data;
`endif
  end

  assign accept    = (state == IDLE) && start;
  assign in_flight = (state == CAPTURE) || (state == DRAIN);
  assign do_write  = in_flight && row_complete;

  wb_deskew_buffer #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .WORD_SIZE (WORD_SIZE),
    .CNT_W     (CNT_W)
  ) u_buf (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .capture_en   (in_flight),
    .eff_valid    (eff_valid),
    .eff_data     (eff_data),
    .rd_row       (wr_row),
    .row_complete (row_complete),
    .rd_data      (rd_data),
    .all_full     (all_full),
    .overflow     (overflow)
  );

  // Next-state logic; finishing the last row wins over entering DRAIN.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (wr_row == LAST) state_nx = DONE;
               else if (all_full) state_nx = DRAIN;
      DRAIN:   if (wr_row == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with registered busy/done decoded from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == CAPTURE) || (state_nx == DRAIN);
      done  <= (state_nx == DONE);
    end
  end

  // Row pointer and sticky overflow flag, both cleared by an accepted start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_row       <= '0;
      overflow_err <= 1'b0;
    end else if (accept) begin
      wr_row       <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (do_write) wr_row <= wr_row + 1'b1;
      if (overflow) overflow_err <= 1'b1;
    end
  end

  // BRAM write port: single-cycle strobe, address/data held between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_mem_wr_en   <= 1'b0;
      out_mem_addr    <= '0;
      out_mem_wr_data <= '0;
    end else begin
      out_mem_wr_en <= do_write;
      if (do_write) begin
        out_mem_addr    <= MEM_ADDR_W'(BASE_ADDR) + MEM_ADDR_W'(wr_row);
        out_mem_wr_data <= rd_data;
      end
    end
  end

endmodule

// File: doc/systolic_output_writeback.md
# systolic_output_writeback

Output write-back stage directly downstream of the systolic array's bottom edge. It captures the column-skewed result words from the array's bottom output bus, de-skews them into complete output rows, and writes each row as one word to the output BRAM. It signals completion once all `ROWS` rows of a result matrix have been written.

## Interface
Parameters:
- `ROWS`, default 4: result rows per matrix.
- `COLS`, default 4: array columns.
- `WORD_SIZE`, default 16: bits per result element.
- `MEM_PORT_WIDTH`, default `COLS*WORD_SIZE`: BRAM word width. Must equal `COLS*WORD_SIZE`.
- `BASE_ADDR`, default 0: BRAM address of result row 0.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — reset. Asynchronous and active-low.
- `start`  in  1  — one-cycle pulse that arms capture of a new matrix.
- `col_valid`  in  `COLS`  — per-column result valid from the array.
- `col_data`  in  `COLS*WORD_SIZE`  — bottom output bus; column c occupies `[c*WORD_SIZE +: WORD_SIZE]`.
- `proxy_valid`  in  `COLS`  — weight-proxy valid. Present only with `WPROXY_MERGE_EN`.
- `proxy_data`  in  `COLS*WORD_SIZE`  — weight-proxy data. Present only with `WPROXY_MERGE_EN`.
- `out_mem_addr`  out  32  — BRAM write address.
- `out_mem_wr_en`  out  1  — BRAM write strobe.
- `out_mem_wr_data`  out  `MEM_PORT_WIDTH`  — one result row; column c at `[c*WORD_SIZE +: WORD_SIZE]`.
- `busy`  out  1  — high from accepted `start` until `done`.
- `done`  out  1  — one-cycle pulse after the last row is written.
- `overflow_err`  out  1  — sticky; cleared only by `rst` or an accepted `start`.

## Operation
- States:
  - IDLE: `start` goes to CAPTURE and clears counters and the error flag.
  - CAPTURE: moves to DRAIN once every column count equals `ROWS`.
  - DRAIN: moves to DONE when the final row is written.
  - DONE: lasts one cycle, then returns to IDLE.
- Per-column counter `col_cnt[c]`, width `$clog2(ROWS+1)`. On an effective valid for column c in CAPTURE:
  - store the data into buffer entry `[col_cnt[c]][c]`;
  - increment `col_cnt[c]`.
- Row pointer `wr_row`. Row `wr_row` is complete when `col_cnt[c] > wr_row` for all c. A complete row is written the following cycle:
  - `out_mem_addr = BASE_ADDR + wr_row`;
  - `wr_en = 1`;
  - `wr_row` increments.
- At most one row write per cycle. Rows are always written in order 0 through `ROWS-1`.
- A valid arriving when `col_cnt[c] == ROWS` is dropped and sets `overflow_err`.
- Valids in IDLE or DONE are ignored silently.
- `start` while `busy` is ignored.
- `start` coinciding with the DONE cycle is ignored; a new `start` must be pulsed in IDLE.
- Reset mid-operation returns to IDLE immediately.
  - All outputs go to 0 and counters clear.
  - Buffer contents are don't-care.
  - No partial row is written after reset.
- Data is passed through unmodified. No arithmetic, no truncation.

## Timing
- Reset values: `out_mem_addr=0`, `out_mem_wr_en=0`, `out_mem_wr_data=0`, `busy=0`, `done=0`, `overflow_err=0`, state IDLE.
- All outputs are registered.
- `busy` rises the cycle after `start` is sampled.
- Latency: the write for row r is asserted the cycle after the edge that captured the last outstanding element of row r. With the array's skew, that element is normally column `COLS-1`.
- With skew where column c, row r arrives at cycle `t0+r+c`:
  - row r is written at `t0+r+COLS`;
  - `done` pulses at `t0+ROWS+COLS` (the cycle after the last write), and `busy` falls in the same cycle.
- `out_mem_wr_en` is a single-cycle strobe per row. Address and data are stable in that cycle.

## Configuration
- Macro: `WPROXY_MERGE_EN`.
- Defined:
  - `proxy_valid` and `proxy_data` ports exist.
  - Effective valid for column c is `col_valid[c] | proxy_valid[c]`.
  - Data comes from `proxy_data` when `proxy_valid[c]`, otherwise from `col_data`.
  - When both valids are high, the proxy wins and the element counts once.
- Undefined: the proxy ports are absent, effective valid is `col_valid`, and data is `col_data`.

## Structure
- Shared package `systolic_pkg` holds:
  - the writeback state enum `wb_state_t` (IDLE, CAPTURE, DRAIN, DONE);
  - the row-word type sized `COLS*WORD_SIZE`;
  - address-width constant `MEM_ADDR_W = 32`.
- One sub-module, `wb_deskew_buffer`: the `ROWS x COLS` storage plus per-column counters, with a row-complete output.
- The FSM and the BRAM port logic stay in the top.

## Test plan
- 4x4, `WORD_SIZE=16`, skewed valids carrying rows [67 43 81 23], [85 101 173 38], [80 114 232 43], [71 94 220 37] → four writes:
  - addr 0 with data {23,81,43,67}, then addrs 1–3 with the matching rows;
  - `done` one cycle after the addr-3 write;
  - `overflow_err=0`.
- Same stimulus with `BASE_ADDR=16` → writes to addrs 16–19, data unchanged.
- A fifth valid on column 2 after its four elements → dropped, `overflow_err=1`, written data unchanged, `done` still pulses.
- `rst` asserted after row 1 is written → outputs 0 immediately, no further writes. A new `start` then a full matrix → rows 0–3 written correctly.
- `start` pulsed while `busy`, and valids in IDLE → no state change and no writes.
- `WPROXY_MERGE_EN` on, `proxy_valid[1]` with value 999 on every column-1 beat while `col_data` column 1 is 0 → every row has 999 in column 1.
